// File: rtl/brightness_pkg.sv
// Shared definitions for the brightness systolic array result path.
//  - collector_state_e : collector FSM states
//  - LANE_WIDTH        : width of one array output lane
//  - CHUNK_LANES       : number of lanes on the wave bus (tile side)
//  - NUM_WAVES         : skewed wavefronts needed to cover one tile
//  - PIX_MAX           : largest representable output pixel
//  - clamp_pixel       : saturate a signed lane value into an 8-bit pixel
package brightness_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    NEXT    = 3'd3,
    DONE    = 3'd4
  } collector_state_e;

  localparam int LANE_WIDTH  = 16;
  localparam int CHUNK_LANES = 4;
  localparam int NUM_WAVES   = 2 * CHUNK_LANES - 1;
  localparam logic [7:0] PIX_MAX = 8'd255;

  // Negative values floor at black, anything above PIX_MAX saturates at white.
  function automatic logic [7:0] clamp_pixel(input logic signed [15:0] s);
    logic [7:0] p;
    if (s < 16'sd0) begin
      p = 8'd0;
    end else if (s > 16'sd255) begin
      p = PIX_MAX;
    end else begin
      p = s[7:0];
    end
    return p;
  endfunction

endpackage

// File: rtl/tile_deskew_buffer.sv
// Tile de-skew storage for one 4x4 tile of 16-bit array results.
// Wavefront k carries lane i's element for column k-i, so each accepted wave
// fills one anti-diagonal; lanes whose column falls outside 0..3 are dropped.
// Ports:
//  clk      in   clock
//  wr_en    in   store the lanes of the current wavefront
//  wave_idx in   index k (0..6) of the current wavefront
//  lanes    in   4 x 16-bit lanes, lane i at lanes[16*i +: 16] (lane i = tile row i)
//  rd_r     in   read row
//  rd_c     in   read column
//  rd_data  out  element at [rd_r][rd_c]
module tile_deskew_buffer
  import brightness_pkg::*;
(
  input  logic                            clk,
  input  logic                            wr_en,
  input  logic [2:0]                      wave_idx,
  input  logic [CHUNK_LANES*LANE_WIDTH-1:0] lanes,
  input  logic [1:0]                      rd_r,
  input  logic [1:0]                      rd_c,
  output logic [LANE_WIDTH-1:0]           rd_data
);

  logic [LANE_WIDTH-1:0] mem_r [CHUNK_LANES][CHUNK_LANES];
  logic [3:0]            col_s [CHUNK_LANES];

  // Column targeted by each lane; negative differences wrap to >= 4 and are dropped.
  always_comb begin
    for (int i = 0; i < CHUNK_LANES; i++) begin
      col_s[i] = {1'b0, wave_idx} - 4'(i);
    end
  end

  // Store every in-range lane of an accepted wavefront into its diagonal slot.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < CHUNK_LANES; i++) begin
        if (col_s[i] < 4'd4) begin
          mem_r[i][col_s[i][1:0]] <= lanes[LANE_WIDTH*i +: LANE_WIDTH];
        end
      end
    end
  end

  assign rd_data = mem_r[rd_r][rd_c];

endmodule

// File: rtl/systolic_result_collector.sv
// Collects skewed output wavefronts of the brightness systolic array, one tile
// at a time, de-skews them, clamps to 8-bit pixels and writes each tile
// row-major into the output RAM at its offset. Tiles are walked row-major over
// the whole image; done pulses once after the last tile.
// Ports:
//  clk, reset   clock, synchronous active-high reset
//  start        begin an image (honoured only in IDLE)
//  wave_valid   wave_data holds a wavefront
//  wave_data    4 lanes x 16-bit signed, lane i at [16*i +: 16]
//  wave_ready   high while collecting
//  ram_wr_en    output RAM write strobe
//  ram_wr_addr  output RAM word address
//  ram_wr_data  clamped pixel
//  busy         high whenever not IDLE
//  done         one-cycle pulse at the end of the image
module systolic_result_collector
  import brightness_pkg::*;
#(
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 8,
  parameter int MATRIX_SIZE = 8,
  parameter int CHUNK_SIZE  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  wave_valid,
  input  logic [63:0]           wave_data,
  output logic                  wave_ready,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH:0] MS_W     = (ADDR_WIDTH+1)'(MATRIX_SIZE);
  localparam logic [ADDR_WIDTH:0] CS_W     = (ADDR_WIDTH+1)'(CHUNK_SIZE);
  localparam logic [ADDR_WIDTH:0] LAST_OFF = MS_W - CS_W;

  collector_state_e      state_r, state_nxt_s;
  logic [2:0]            wave_cnt_r;
  logic [3:0]            wr_idx_r;
  logic [ADDR_WIDTH:0]   row_off_r, col_off_r;
  logic                  xfer_s;
  logic                  last_tile_s;
  logic [3:0]            rd_idx_s;
  logic [LANE_WIDTH-1:0] rd_data_s;
  logic [ADDR_WIDTH:0]   row_s, col_s, addr_full_s;

  logic                  wave_ready_r, busy_r, done_r, ram_wr_en_r;
  logic [ADDR_WIDTH-1:0] ram_wr_addr_r;
  logic [DATA_WIDTH-1:0] ram_wr_data_r;

  assign xfer_s      = wave_valid && (state_r == COLLECT);
  assign last_tile_s = (row_off_r == LAST_OFF) && (col_off_r == LAST_OFF);

  tile_deskew_buffer u_buf (
    .clk      (clk),
    .wr_en    (xfer_s),
    .wave_idx (wave_cnt_r),
    .lanes    (wave_data),
    .rd_r     (rd_idx_s[3:2]),
    .rd_c     (rd_idx_s[1:0]),
    .rd_data  (rd_data_s)
  );

  // Next-state logic for the collector FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = COLLECT;
        else       state_nxt_s = IDLE;
      end
      COLLECT: begin
        if (xfer_s && (wave_cnt_r == 3'(NUM_WAVES - 1))) state_nxt_s = WRITE;
        else                                              state_nxt_s = COLLECT;
      end
      WRITE: begin
        if (wr_idx_r == 4'd15) state_nxt_s = NEXT;
        else                   state_nxt_s = WRITE;
      end
      NEXT: begin
        if (last_tile_s) state_nxt_s = DONE;
        else             state_nxt_s = COLLECT;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Outputs are registered one pixel ahead: while WRITE shows pixel j the
  // buffer is already being read for pixel j+1 (pixel 0 on entry to WRITE).
  always_comb begin
    rd_idx_s = 4'd0;
    if (state_r == WRITE) begin
      rd_idx_s = wr_idx_r + 4'd1;
    end else begin
      rd_idx_s = 4'd0;
    end
    row_s       = {{(ADDR_WIDTH-1){1'b0}}, rd_idx_s[3:2]};
    col_s       = {{(ADDR_WIDTH-1){1'b0}}, rd_idx_s[1:0]};
    addr_full_s = (row_off_r + row_s) * MS_W + col_off_r + col_s;
  end

  // FSM state register and state-derived status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      wave_ready_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      wave_ready_r <= (state_nxt_s == COLLECT);
      busy_r       <= (state_nxt_s != IDLE);
      done_r       <= (state_nxt_s == DONE);
    end
  end

  // Wave counter: counts accepted wavefronts of the current tile.
  always_ff @(posedge clk) begin
    if (reset) begin
      wave_cnt_r <= 3'd0;
    end else if (state_r != COLLECT) begin
      wave_cnt_r <= 3'd0;
    end else if (xfer_s) begin
      if (state_nxt_s == WRITE) wave_cnt_r <= 3'd0;
      else                      wave_cnt_r <= wave_cnt_r + 3'd1;
    end
  end

  // Write index: steps once per WRITE cycle, wraps to 0 after pixel 15.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx_r <= 4'd0;
    end else if (state_r == WRITE) begin
      wr_idx_r <= wr_idx_r + 4'd1;
    end else begin
      wr_idx_r <= 4'd0;
    end
  end

  // Tile offsets: advance row-major in NEXT, return to origin after the last tile.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_off_r <= '0;
      col_off_r <= '0;
    end else if (state_r == NEXT) begin
      if (last_tile_s) begin
        row_off_r <= '0;
        col_off_r <= '0;
      end else if ((col_off_r + CS_W) >= MS_W) begin
        col_off_r <= '0;
        row_off_r <= row_off_r + CS_W;
      end else begin
        col_off_r <= col_off_r + CS_W;
      end
    end
  end

  // RAM write port registers, loaded for every cycle that will be a WRITE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_wr_en_r   <= 1'b0;
      ram_wr_addr_r <= '0;
      ram_wr_data_r <= '0;
    end else if (state_nxt_s == WRITE) begin
      ram_wr_en_r   <= 1'b1;
      ram_wr_addr_r <= addr_full_s[ADDR_WIDTH-1:0];
      ram_wr_data_r <= DATA_WIDTH'(clamp_pixel($signed(rd_data_s)));
    end else begin
      ram_wr_en_r   <= 1'b0;
    end
  end

  assign wave_ready  = wave_ready_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign ram_wr_en   = ram_wr_en_r;
  assign ram_wr_addr = ram_wr_addr_r;
  assign ram_wr_data = ram_wr_data_r;

endmodule

// File: tb/tb_systolic_result_collector.sv
// Directed bench for systolic_result_collector: full images, clamping,
// valid stalls, tile ordering, mid-write reset and ignored start pulses.
module tb_systolic_result_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        wave_valid;
  logic [63:0] wave_data;
  logic        wave_ready;
  logic        ram_wr_en;
  logic [5:0]  ram_wr_addr;
  logic [7:0]  ram_wr_data;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  int cyc        = 0;
  int wr_total   = 0;
  int done_total = 0;
  int wr_addr_log [1024];
  int wr_data_log [1024];
  int wr_cyc_log  [1024];
  int done_cyc_log[64];

  systolic_result_collector #(
    .ADDR_WIDTH(6), .DATA_WIDTH(8), .MATRIX_SIZE(8), .CHUNK_SIZE(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .wave_valid(wave_valid),
    .wave_data(wave_data), .wave_ready(wave_ready), .ram_wr_en(ram_wr_en),
    .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Record every RAM write and done pulse, sampled on the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (ram_wr_en) begin
      if (wr_total < 1024) begin
        wr_addr_log[wr_total] = 32'(ram_wr_addr);
        wr_data_log[wr_total] = 32'(ram_wr_data);
        wr_cyc_log[wr_total]  = cyc;
      end
      wr_total = wr_total + 1;
    end
    if (done) begin
      if (done_total < 64) done_cyc_log[done_total] = cyc;
      done_total = done_total + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Wavefront k of a tile: lane i carries element (i, k-i); out-of-range lanes hold junk.
  function automatic logic [63:0] mk_wave(input int mode, input int k);
    logic [63:0] w;
    logic [15:0] v;
    int j;
    w = 64'd0;
    for (int i = 0; i < 4; i++) begin
      j = k - i;
      if (j >= 0 && j <= 3) begin
        if (mode == 0) begin
          v = 16'(16 * i + j);
        end else begin
          case (i)
            0:       v = 16'hFFFF;
            1:       v = 16'h0100;
            2:       v = 16'h00FF;
            default: v = 16'h0000;
          endcase
        end
      end else begin
        v = 16'hDEAD;
      end
      w[16*i +: 16] = v;
    end
    return w;
  endfunction

  // Expected pixel at an image address for a stimulus mode.
  function automatic int exp_pix(input int mode, input int a);
    int r, c;
    r = (a >> 3) & 3;
    c = a & 3;
    if (mode == 0) return 16 * r + c;
    else if (r == 1 || r == 2) return 255;
    else return 0;
  endfunction

  // Feed ntiles tiles of 7 wavefronts each; optional idle cycle before waves 1..6.
  task automatic run_tiles(input int mode, input bit stall, input int ntiles);
    int n;
    for (int t = 0; t < ntiles; t++) begin
      for (int k = 0; k < 7; k++) begin
        if (stall && k > 0) begin
          @(negedge clk);
          wave_valid = 1'b0;
          check_eq("ready_in_stall", 32'(wave_ready), 32'd1);
          if (k == 6) check_eq("no_write_before_w6", 32'(ram_wr_en), 32'd0);
        end
        @(negedge clk);
        wave_valid = 1'b1;
        wave_data  = mk_wave(mode, k);
        n = 0;
        while (!wave_ready && n < 200) begin
          @(negedge clk);
          n = n + 1;
        end
        if (n >= 200) check_eq("ready_timeout", 32'd0, 32'd1);
        if (k == 6) check_eq("no_write_at_w6", 32'(ram_wr_en), 32'd0);
        @(posedge clk);
        if (k == 6) begin
          @(negedge clk);
          check_eq("first_write_en", 32'(ram_wr_en), 32'd1);
          check_eq("first_write_addr", 32'(ram_wr_addr), 32'(((t / 2) * 4) * 8 + (t % 2) * 4));
        end
      end
    end
    wave_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n = n + 1;
    end
    check_eq("done_seen", 32'(done), 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Check one full image worth of writes starting at log index base.
  task automatic verify_image(input int base, input int mode, input string tag);
    int hits[64];
    int a;
    for (int i = 0; i < 64; i++) hits[i] = 0;
    check_eq({tag, "_count"}, 32'(wr_total - base), 32'd64);
    for (int i = 0; i < 64; i++) begin
      a = wr_addr_log[base + i];
      if (a >= 0 && a < 64) hits[a] = hits[a] + 1;
      check_eq({tag, "_data"}, 32'(wr_data_log[base + i]), 32'(exp_pix(mode, a)));
    end
    for (int i = 0; i < 64; i++) check_eq({tag, "_hit"}, 32'(hits[i]), 32'd1);
  endtask

  initial begin
    int base, dbase;
    reset      = 1'b1;
    start      = 1'b0;
    wave_valid = 1'b0;
    wave_data  = 64'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(wave_ready), 32'd0);
    check_eq("rst_wr_en", 32'(ram_wr_en), 32'd0);
    check_eq("rst_busy",  32'(busy), 32'd0);
    check_eq("rst_done",  32'(done), 32'd0);
    check_eq("rst_addr",  32'(ram_wr_addr), 32'd0);
    check_eq("rst_data",  32'(ram_wr_data), 32'd0);
    reset = 1'b0;

    // Single image, in-tile ramp values, valid every cycle.
    base = wr_total; dbase = done_total;
    pulse_start();
    check_eq("t1_busy", 32'(busy), 32'd1);
    check_eq("t1_ready", 32'(wave_ready), 32'd1);
    run_tiles(0, 1'b0, 4);
    wait_done();
    repeat (5) @(negedge clk);
    verify_image(base, 0, "t1");
    check_eq("t1_done_count", 32'(done_total - dbase), 32'd1);
    // The NEXT cycle sits between the final write and the DONE pulse.
    check_eq("t1_done_timing", 32'(done_cyc_log[dbase] - wr_cyc_log[base + 63]), 32'd2);
    check_eq("t4_tile01_px00", 32'(wr_addr_log[base + 16]), 32'd4);
    check_eq("t4_tile10_px33", 32'(wr_addr_log[base + 47]), 32'd59);
    check_eq("t1_idle_busy", 32'(busy), 32'd0);

    // Clamping of negative, over-range, max and zero lanes.
    base = wr_total;
    pulse_start();
    run_tiles(1, 1'b0, 4);
    wait_done();
    repeat (5) @(negedge clk);
    verify_image(base, 1, "t2");

    // Valid toggling 1-0-1-0 during collection.
    base = wr_total;
    pulse_start();
    run_tiles(0, 1'b1, 4);
    wait_done();
    repeat (5) @(negedge clk);
    verify_image(base, 0, "t3");

    // Reset during write index 5 of tile 2.
    dbase = done_total;
    pulse_start();
    run_tiles(0, 1'b0, 3);
    repeat (5) @(negedge clk);
    check_eq("t5_idx5_en", 32'(ram_wr_en), 32'd1);
    check_eq("t5_idx5_addr", 32'(ram_wr_addr), 32'd41);
    reset = 1'b1;
    @(negedge clk);
    check_eq("t5_rst_wr_en", 32'(ram_wr_en), 32'd0);
    check_eq("t5_rst_busy", 32'(busy), 32'd0);
    check_eq("t5_rst_ready", 32'(wave_ready), 32'd0);
    reset = 1'b0;
    #1;
    base = wr_total;
    repeat (10) @(negedge clk);
    #1;
    check_eq("t5_no_writes", 32'(wr_total - base), 32'd0);
    check_eq("t5_no_done", 32'(done_total - dbase), 32'd0);

    // Restart from tile (0,0); start held into COLLECT and pulsed on DONE is ignored.
    base = wr_total; dbase = done_total;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check_eq("t6_busy", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    run_tiles(0, 1'b0, 4);
    wait_done();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("t6_first_addr", 32'(wr_addr_log[base]), 32'd0);
    verify_image(base, 0, "t6");
    check_eq("t6_done_count", 32'(done_total - dbase), 32'd1);
    check_eq("t6_idle_busy", 32'(busy), 32'd0);
    check_eq("t6_idle_ready", 32'(wave_ready), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
